// File: rtl/mult.sv
// Iterative radix-2 Booth signed multiplier.
// Takes one Booth step per clock, so a product is ready WIDTH+1 clocks after
// start is sampled. The operands are held in internal registers, so A and B
// are free to change once the capture edge has passed.
module mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   C,
    output logic                 busy,
    output logic                 done
);

    // The step counter has to hold values up to WIDTH-1.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LASTSTEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state;
    state_t nextstate;

    // The accumulator and the multiplicand are one bit wider than the operands,
    // so subtracting the most negative value cannot overflow.
    logic [WIDTH:0]    acc;
    logic [WIDTH:0]    mcand;
    logic [WIDTH-1:0]  mplier;
    logic              qm1;
    logic [CW-1:0]     cnt;

    logic              load;
    logic              step;
    logic              finish;

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    accnext;
    logic [WIDTH-1:0]  mpliernext;
    logic              qm1next;

    // State register. Reset forces IDLE, which aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextstate;
        end
    end

    // Next-state decode and datapath controls. start is only looked at in IDLE.
    always_comb begin
        nextstate = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    nextstate = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LASTSTEP) begin
                    nextstate = FINISH;
                end
            end
            FINISH: begin
                busy      = 1'b1;
                finish    = 1'b1;
                nextstate = IDLE;
            end
            default: begin
                nextstate = IDLE;
            end
        endcase
    end

    // One Booth step. The pair {q0, q-1} selects subtract, add or no-op, and
    // an arithmetic shift right of {acc, mplier, q-1} follows.
    always_comb begin
        sum = acc;
        case ({mplier[0], qm1})
            2'b10:   sum = acc - mcand;
            2'b01:   sum = acc + mcand;
            default: sum = acc;
        endcase
        accnext    = {sum[WIDTH], sum[WIDTH:1]};
        mpliernext = {sum[0], mplier[WIDTH-1:1]};
        qm1next    = mplier[0];
    end

    // Datapath registers. Operands are captured on the load edge, and C plus
    // the done pulse update only on the FINISH edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            qm1    <= 1'b0;
            cnt    <= '0;
            C      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                mcand  <= {A[WIDTH-1], A};
                mplier <= B;
                acc    <= '0;
                qm1    <= 1'b0;
                cnt    <= '0;
            end else if (step) begin
                acc    <= accnext;
                mplier <= mpliernext;
                qm1    <= qm1next;
                cnt    <= cnt + 1'b1;
            end else if (finish) begin
                C    <= {acc[WIDTH-1:0], mplier};
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult.sv
// Testbench for mult with WIDTH=8. Every expected product comes from plain
// signed integer multiplication. Inputs are driven and outputs are sampled on
// the falling clock edge.
module tb_mult;

    localparam int W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   c;
    logic             busy;
    logic             done;

    int checkCount = 0;
    int errorCount = 0;

    mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .C     (c),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the exact signed product, truncated to 2*W bits.
    function automatic logic [2*W-1:0] refProduct(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[2*W-1:0];
    endfunction

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sets start for one sampling edge, then scrambles A and B. The task
    // returns at the falling edge that follows the capture edge.
    task automatic startOp(input logic [W-1:0] x, input logic [W-1:0] y);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Waits for done within a bounded number of cycles. The returned count is
    // the number of clocks that pass after the capture edge.
    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Runs one complete operation and checks busy, latency, the product and
    // the one-cycle width of the done pulse.
    task automatic applyStimulus(input string tag, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
        int n;
        logic [2*W-1:0] exp;
        exp = refProduct(x, y);
        startOp(x, y);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        waitDone(n);
        checkOutput({tag, " latency"}, 32'(n), 32'(W + 1));
        checkOutput({tag, " C"}, 32'(c), 32'(exp));
        @(negedge clk);
        checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
        checkOutput({tag, " C hold"}, 32'(c), 32'(exp));
    endtask

    initial begin
        int n;
        int doneSeen;
        logic [2*W-1:0] capturedC;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset C", 32'(c), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operand pairs, including the most negative corner cases.
        applyStimulus("3*5", 8'd3, 8'd5);
        checkOutput("3*5 const", 32'(c), 32'h000F);
        applyStimulus("-1*-1", 8'hFF, 8'hFF);
        checkOutput("-1*-1 const", 32'(c), 32'h0001);
        applyStimulus("-128*-128", 8'h80, 8'h80);
        checkOutput("-128*-128 const", 32'(c), 32'h4000);
        applyStimulus("-128*127", 8'h80, 8'h7F);
        checkOutput("-128*127 const", 32'(c), 32'hC080);
        applyStimulus("0*-77", 8'h00, 8'hB3);
        checkOutput("0*-77 const", 32'(c), 32'h0000);

        // Random signed operand pairs.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus("random", ra, rb);
        end

        // Sparse sweep of non-negative pairs with i+j <= 127.
        for (int i = 0; i <= 127; i += 9) begin
            for (int j = 0; i + j <= 127; j += 11) begin
                startOp(W'(i), W'(j));
                waitDone(n);
                checkOutput("sweep", 32'(c), 32'(i * j));
            end
        end
        @(negedge clk);

        // A second start at k+3 must be ignored, and A/B changes must not leak in.
        startOp(8'd13, 8'hF6);
        @(negedge clk);
        @(negedge clk);
        a = 8'd99;
        b = 8'd77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        doneSeen = 0;
        capturedC = '0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                doneSeen++;
                capturedC = c;
            end
            @(negedge clk);
        end
        checkOutput("ignored start done count", 32'(doneSeen), 32'd1);
        checkOutput("ignored start C", 32'(capturedC), 32'(refProduct(8'd13, 8'hF6)));

        // Reset at k+4 aborts the operation with no done pulse.
        startOp(8'd50, 8'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort C", 32'(c), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'd0);
        checkOutput("abort C stays 0", 32'(c), 32'd0);
        applyStimulus("6*-7", 8'd6, 8'hF9);
        checkOutput("6*-7 const", 32'(c), 32'hFFD6);

        // Back-to-back: start is asserted during the done cycle.
        startOp(8'd100, 8'h9C);
        waitDone(n);
        checkOutput("b2b first C", 32'(c), 32'(refProduct(8'd100, 8'h9C)));
        startOp(8'hC5, 8'd37);
        waitDone(n);
        checkOutput("b2b second latency", 32'(n), 32'(W + 1));
        checkOutput("b2b second C", 32'(c), 32'(refProduct(8'hC5, 8'd37)));
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mult.md
MULT -- requirements
Module: mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-004 start  input  1  request to begin a multiplication; honoured only in IDLE.
REQ-005 A  input  WIDTH  multiplicand, two's-complement signed.
REQ-006 B  input  WIDTH  multiplier, two's-complement signed.
REQ-007 C  output  2*WIDTH  signed product A*B, registered, held between operations.
REQ-008 busy  output  1  high while an operation is in progress (RUN or FINISH).
REQ-009 done  output  1  one-cycle pulse marking a new valid C.

Function
REQ-010 The block SHALL be an iterative radix-2 Booth signed multiplier with FSM states IDLE, RUN, FINISH.
REQ-011 In IDLE with start=1 at edge k, A and B SHALL be captured into internal registers, the step counter cleared, and the state SHALL go to RUN.
REQ-012 Input changes on A and B after the capture edge SHALL NOT affect the operation in progress.
REQ-013 RUN SHALL perform one Booth step per cycle: examine multiplier LSB pair (q0, q-1); 10 subtracts multiplicand, 01 adds it, 00/11 no-op; then arithmetic shift right of {accumulator, multiplier, q-1}.
REQ-014 The accumulator SHALL be WIDTH+1 bits wide so the most negative multiplicand is handled without overflow.
REQ-015 After exactly WIDTH steps (edges k+1..k+WIDTH), the state SHALL go to FINISH.
REQ-016 At edge k+WIDTH+1, C SHALL load the 2*WIDTH-bit product, done SHALL go high for exactly one cycle, and the state SHALL return to IDLE.
REQ-017 Total latency SHALL be WIDTH+1 clocks from the start-sampling edge to done high.
REQ-018 busy SHALL be high from edge k through edge k+WIDTH+1, and low in IDLE.
REQ-019 start while busy=1 SHALL be ignored with no queuing.
REQ-020 A start sampled in the same cycle that done is high (state IDLE) SHALL begin a new operation; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-021 C SHALL equal the exact mathematical product for all signed operand pairs, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2).
REQ-022 C SHALL change only on the done edge or on reset.
REQ-023 The output SHALL be sign-correct for every combination of operand signs, and a zero operand SHALL give C=0.

Reset
REQ-024 With rst_n=0 at a rising edge: state=IDLE, C=0, busy=0, done=0, and internal operand, accumulator and counter registers cleared.
REQ-025 Reset SHALL take priority over start and over any in-progress operation.
REQ-026 Reset during an operation SHALL abort it with no done pulse, and C SHALL read 0.
REQ-027 The first start after rst_n returns high SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 A=3, B=5, start pulse -> done exactly 9 cycles later, C=16'h000F.
REQ-029 A=-1, B=-1 -> C=16'h0001; A=-128, B=-128 -> C=16'h4000; A=-128, B=127 -> C=16'hC080; A=0, B=-77 -> C=16'h0000.
REQ-030 Sweep all i, j >= 0 with i+j <= 127 -> each C = i*j, matching zero-extended binary.
REQ-031 Start at k, change A/B and pulse start again at k+3 -> a single done with the product of the originally captured operands.
REQ-032 Start, then rst_n=0 at k+4 -> no done pulse, busy=0, C=0; a subsequent start of 6*(-7) -> C=16'hFFD6.
REQ-033 Start asserted during the done cycle -> a second done exactly WIDTH+1 cycles later with the correct product.
